pc_word_deserializer: RTL
=========================

PC_WORD_DESERIALIZER -- requirements
Module: pc_word_deserializer

Interface
REQ-001 Parameter NPCcode, default 7, SHALL set the width of the serialized code field (minimum 7).
REQ-002 Parameter NPCdata, default 20, SHALL set the width of the serialized payload chunk; output payload width is 2*NPCdata-2 (38 at default).
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_code  input  NPCcode  SHALL carry the chunk code: [3:0] leaf, [4] chunk index, [5] last flag, [6] reserved (must be 0), bits above 6 ignored.
REQ-006 in_payload  input  NPCdata  SHALL carry the chunk data.
REQ-007 in_v  input  1  SHALL indicate that the input chunk is valid.
REQ-008 in_a  output  1  SHALL indicate that the input chunk is accepted.
REQ-009 out_leaf_code  output  4  SHALL carry the leaf of the reassembled BD word.
REQ-010 out_payload  output  2*NPCdata-2  SHALL carry the reassembled payload.
REQ-011 out_v  output  1  SHALL indicate that the output word is valid.
REQ-012 out_a  input  1  SHALL indicate that the consumer accepts the output word.
REQ-013 err  output  1  SHALL pulse for one cycle for each rejected chunk.
REQ-014 err_count  output  8  SHALL count rejected chunks, saturating at 255.

Function
REQ-015 A transfer SHALL occur on any cycle with v&&a on the respective channel; chunks not transferred SHALL have no effect.
REQ-016 in_a SHALL equal !out_v || out_a (combinational), so a new chunk may be accepted in the same cycle the output drains.
REQ-017 An accepted chunk is bad if code[6]=1 or leaf=4'hF.
REQ-018 A bad chunk SHALL be dropped, SHALL pulse err, and SHALL discard any stored partial word; the FSM SHALL return to FIRST.
REQ-019 The FSM SHALL have two states, FIRST (reset state) and SECOND, and SHALL hold a 20-bit lo register and a 4-bit leaf register.
REQ-020 FIRST, good chunk, idx=0, last=1: the next-cycle outputs SHALL be out_v=1, out_leaf_code=leaf and out_payload={18'b0,payload}; the FSM SHALL stay in FIRST.
REQ-021 FIRST, good chunk, idx=0, last=0: the FSM SHALL store lo=payload and leaf, go to SECOND, and produce no output.
REQ-022 FIRST, good chunk, idx=1: the chunk SHALL be dropped with an err pulse, and the FSM SHALL stay in FIRST.
REQ-023 SECOND, good chunk, idx=1, last=1, leaf equal to the stored leaf: the next-cycle output SHALL be out_payload={payload[17:0],lo} (payload[19:18] discarded) with out_v=1; the FSM SHALL go to FIRST.
REQ-024 SECOND, idx=1 with last=0 or with a leaf mismatch: the stored partial and the chunk SHALL be dropped with an err pulse; the FSM SHALL go to FIRST.
REQ-025 SECOND, good chunk, idx=0: the stored partial SHALL be discarded with an err pulse, and the chunk SHALL be processed as in FIRST (REQ-020/021) in the same cycle.
REQ-026 Latency SHALL be 1 cycle from acceptance of the completing chunk to out_v=1; sustained throughput SHALL be one chunk per cycle when out_a=1.
REQ-027 While out_v=1 and out_a=0, out_leaf_code and out_payload SHALL be held stable and in_a SHALL be 0.
REQ-028 out_v SHALL clear after an output transfer unless a word completes in the same cycle.
REQ-029 err_count SHALL increment on each err pulse, stay at 255 once reached, and be otherwise unaffected.

Reset
REQ-030 While reset=1: out_v=0, out_leaf_code=0, out_payload=0, err=0, err_count=0, FSM=FIRST, lo=0, stored leaf=0; in_a=1 follows from out_v=0.
REQ-031 Reset asserted mid-word SHALL discard the partial word; the next idx=1 chunk after reset SHALL be an error.
REQ-032 Reset SHALL take precedence over any simultaneous transfer.

Verification
REQ-033 Single chunk code=7'h25 (leaf 5, idx0, last1), payload=20'hABCDE -> next cycle out_v=1, leaf=5, out_payload=38'h000ABCDE.
REQ-034 Chunk code=7'h03 payload=20'h12345, then chunk code=7'h33 payload=20'hFFFFF -> out_payload={18'h3FFFF,20'h12345}, leaf=3, no err.
REQ-035 Chunk leaf 3 idx0 last0, then chunk leaf 4 idx1 last1 -> no output, err pulses once, err_count=1, FSM=FIRST.
REQ-036 out_a=0 held for 5 cycles with out_v=1 -> in_a=0 and outputs stable; then out_a=1 together with a new single-chunk word -> back-to-back output the following cycle.
REQ-037 300 chunks with code[6]=1 -> 300 err pulses, err_count=255, no out_v.
REQ-038 Reset asserted while in SECOND, then chunk idx1 last1 -> err pulse, no output.

Source files
------------

// File: rtl/pc_word_deserializer.sv
// Reassembles one- or two-chunk PC words into a single wide output word.
// Bad or out-of-order chunks are dropped and reported on err / err_count.
module pc_word_deserializer #(
  parameter int unsigned NPCcode = 7,
  parameter int unsigned NPCdata = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NPCcode-1:0]     in_code,
  input  logic [NPCdata-1:0]     in_payload,
  input  logic                   in_v,
  output logic                   in_a,
  output logic [3:0]             out_leaf_code,
  output logic [2*NPCdata-3:0]   out_payload,
  output logic                   out_v,
  input  logic                   out_a,
  output logic                   err,
  output logic [7:0]             err_count
);

  localparam int unsigned PayW = 2 * NPCdata - 2;

  typedef enum logic {StFirst, StSecond} state_e;

  state_e              state_q, state_d;
  logic [NPCdata-1:0]  lo_q, lo_d;
  logic [3:0]          leaf_q, leaf_d;
  logic                out_v_q, out_v_d;
  logic [3:0]          out_leaf_q, out_leaf_d;
  logic [PayW-1:0]     out_pay_q, out_pay_d;
  logic                err_q, err_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic       accept;
  logic [3:0] c_leaf;
  logic       c_idx, c_last, c_bad;
  logic       start;

  assign c_leaf = in_code[3:0];
  assign c_idx  = in_code[4];
  assign c_last = in_code[5];
  assign c_bad  = in_code[6] || (c_leaf == 4'hF);

  assign in_a   = !out_v_q || out_a;
  assign accept = in_v && in_a;

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    leaf_d     = leaf_q;
    out_v_d    = out_v_q && !out_a;
    out_leaf_d = out_leaf_q;
    out_pay_d  = out_pay_q;
    err_d      = 1'b0;
    start      = 1'b0;

    if (accept) begin
      if (c_bad) begin
        err_d   = 1'b1;
        state_d = StFirst;
      end else begin
        unique case (state_q)
          StFirst: begin
            if (!c_idx) start = 1'b1;
            else        err_d = 1'b1;
          end
          StSecond: begin
            if (c_idx) begin
              state_d = StFirst;
              if (c_last && (c_leaf == leaf_q)) begin
                out_v_d    = 1'b1;
                out_leaf_d = leaf_q;
                out_pay_d  = {in_payload[NPCdata-3:0], lo_q};
              end else begin
                err_d = 1'b1;
              end
            end else begin
              // A fresh first chunk abandons the pending half-word.
              err_d = 1'b1;
              start = 1'b1;
            end
          end
          default: state_d = StFirst;
        endcase
      end
    end

    if (start) begin
      if (c_last) begin
        state_d    = StFirst;
        out_v_d    = 1'b1;
        out_leaf_d = c_leaf;
        out_pay_d  = {{(PayW - NPCdata){1'b0}}, in_payload};
      end else begin
        state_d = StSecond;
        lo_d    = in_payload;
        leaf_d  = c_leaf;
      end
    end

    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StFirst;
      lo_q       <= '0;
      leaf_q     <= '0;
      out_v_q    <= 1'b0;
      out_leaf_q <= '0;
      out_pay_q  <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      leaf_q     <= leaf_d;
      out_v_q    <= out_v_d;
      out_leaf_q <= out_leaf_d;
      out_pay_q  <= out_pay_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign out_v         = out_v_q;
  assign out_leaf_code = out_leaf_q;
  assign out_payload   = out_pay_q;
  assign err           = err_q;
  assign err_count     = err_cnt_q;

endmodule
